// File: rtl/ev20_pkg.sv
// Shared EV20 definitions: default address width and the PC operation encoding
// used by both the instruction decoder and the PC unit.
package ev20_pkg;

    localparam int EV20_AW = 11;

    typedef logic [2:0] pc_op_t;

    localparam pc_op_t OP_INC  = 3'd0;
    localparam pc_op_t OP_LOAD = 3'd1;
    localparam pc_op_t OP_CALL = 3'd2;
    localparam pc_op_t OP_RET  = 3'd3;
    localparam pc_op_t OP_BR   = 3'd4;

endpackage

// File: rtl/ev20_ret_stack.sv
// Hardware return-address stack: DEPTH x AW LIFO with occupancy count.
// Pushes when full and pops when empty are refused, so entries never wrap.
module ev20_ret_stack #(
    parameter int AW    = 11,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           res,
    input  logic           push,
    input  logic           pop,
    input  logic [AW-1:0]  din,
    output logic [AW-1:0]  dout,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty
);

    logic [AW-1:0] entries [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && !full && sp == SPW'(i)) begin
                entries[i] <= din;
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == SPW'(i + 1)) begin
                dout = entries[i];
            end
        end
    end

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);

endmodule

// File: rtl/ev20_pc_unit.sv
// EV20 program counter: increment, jump, relative branch, call and return
// through a hardware return-address stack, with sticky overflow/underflow flags.
module ev20_pc_unit
    import ev20_pkg::*;
#(
    parameter int            AW        = EV20_AW,
    parameter int            OW        = 8,
    parameter int            DEPTH     = 4,
    parameter logic [AW-1:0] RESET_VEC = '0
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         en,
    input  logic                         load,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         br,
    input  logic [AW-1:0]                tgt,
    input  logic [OW-1:0]                off,
    input  logic                         err_clr,
    output logic [AW-1:0]                pc,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         stk_empty,
    output logic                         stk_full,
    output logic                         ovf,
    output logic                         unf
);

    pc_op_t        op;
    logic [AW-1:0] pcInc;
    logic [AW-1:0] pcNext;
    logic [AW-1:0] offExt;
    logic [AW-1:0] stackTop;
    logic          push;
    logic          pop;

    // Only the highest-priority request survives; the rest are dropped.
    always_comb begin
        op = OP_INC;
        if (load) begin
            op = OP_LOAD;
        end else if (call) begin
            op = OP_CALL;
        end else if (ret) begin
            op = OP_RET;
        end else if (br) begin
            op = OP_BR;
        end
    end

    assign pcInc  = pc + AW'(1);
    assign offExt = AW'(signed'(off));
    assign push   = en && (op == OP_CALL);
    assign pop    = en && (op == OP_RET);

    always_comb begin
        pcNext = pcInc;
        case (op)
            OP_LOAD, OP_CALL: pcNext = tgt;
            OP_RET:           pcNext = stk_empty ? pcInc : stackTop;
            OP_BR:            pcNext = pc + offExt;
            default:          pcNext = pcInc;
        endcase
    end

    ev20_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .SPW   ($clog2(DEPTH + 1))
    ) u_stack (
        .clk   (clk),
        .res   (res),
        .push  (push),
        .pop   (pop),
        .din   (pcInc),
        .dout  (stackTop),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pc <= RESET_VEC;
        end else if (en) begin
            pc <= pcNext;
        end
    end

    // Clearing is honoured even while stalled; a fresh error in the same cycle wins.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (err_clr) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (push && stk_full) begin
                ovf <= 1'b1;
            end
            if (pop && stk_empty) begin
                unf <= 1'b1;
            end
        end
    end

endmodule
